hash_msg_feeder: RTL
====================

// Module: hash_msg_feeder
// PURPOSE
//  Upstream front end of the byte-serial DES-Sbox hash core. Accepts message length (len channel) and
//  message bytes (data channel) over valid/ready, buffers bytes in a small FIFO, and drives the core's
//  C_in/M/M_valid byte protocol. Captures the core's 32-bit digest when hash_ready rises and presents
//  it on a valid/ready result channel. Core and feeder share clk and rst_n.
// PARAMETERS
//  FIFO_DEPTH  4   byte FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   reset, asynchronous, active-low
//  s_len_valid     in   1   message length offered
//  s_len           in   64  message length in bytes (0 allowed)
//  s_len_ready     out  1   length accepted when valid&ready
//  s_data_valid    in   1   message byte offered
//  s_data          in   8   message byte
//  s_data_ready    out  1   byte accepted when valid&ready (= FIFO not full)
//  core_M_valid    out  1   to core M_valid
//  core_M          out  8   to core M
//  core_C_in       out  64  to core C_in (latched length)
//  core_hash_ready in   1   from core hash_ready
//  core_digest     in   32  from core digest_out
//  digest_valid    out  1   result available
//  digest          out  32  result digest
//  digest_ready    in   1   result consumed when valid&ready
//  busy            out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, remaining=0, core_C_in=0, digest=0, digest_valid=0, busy=0.
//  Registers: len_r(64), remaining(64), digest(32), digest_valid; core_C_in = len_r.
//  FIFO: push on s_data_valid&s_data_ready in any state (prefetch allowed); pop only as below;
//   push+pop same cycle legal; when full s_data_ready=0; bytes beyond len stay for next message.
//  core_M_valid/core_M combinational from state+FIFO head; core registers them (no extra latency).
//  IDLE: s_len_ready=1; on s_len_valid: len_r<=s_len, remaining<=s_len -> START.
//  START (core init cycle, core idle, must see exactly one M_valid with C_in):
//   len_r==0: core_M_valid=1, core_M=8'h00, no pop -> WAIT.
//   len_r>0 & FIFO nonempty: core_M_valid=1, core_M=head, pop, remaining-=1;
//     -> STREAM if remaining-1>0 else WAIT.  FIFO empty: core_M_valid=0, stay.
//  STREAM: FIFO nonempty: core_M_valid=1, core_M=head, pop, remaining-=1; -> WAIT when it hits 0.
//   FIFO empty: core_M_valid=0 (gap; core skips). Never more than len_r valid bytes per message.
//  WAIT: core_M_valid=0, core_M=0. Core drives hash_ready=0 from the cycle after init, so first
//   cycle with core_hash_ready==1 in WAIT: digest<=core_digest, digest_valid<=1 -> DONE.
//  DONE: digest/digest_valid held; on digest_ready: digest_valid<=0 -> IDLE. s_len_ready=0 here.
//  Outside START/STREAM core_M_valid=0 always (a stray valid would re-init the core).
//  remaining never wraps: decrement only when >0. Length is full 64-bit, no truncation.
//  Reset mid-operation: immediate return to reset values, FIFO contents discarded, in-flight
//   message lost; core reset in parallel so no partial state survives.
//  Latency (no gaps): len accept -> last byte = 1+N cycles; core adds 1 compute + 1 final cycle;
//   digest_valid 1 cycle after core_hash_ready seen.
// TESTING (digest checked against C/Python golden model of the core)
//  1 len=3, bytes 61 62 63 preloaded -> 3 consecutive core_M_valid, first with core_C_in=3;
//    digest_valid=1 with golden("abc"); exactly 3 pops.
//  2 len=0, no data -> single core_M_valid cycle with core_M=00, core_C_in=0; digest=golden("").
//  3 len=5, s_data_valid toggling 1010.. -> core_M_valid low on empty-FIFO cycles, exactly 5
//    valid bytes delivered, digest=golden of the 5 bytes.
//  4 digest_ready held 0 for 10 cycles -> digest/digest_valid stable, s_len_ready=0, new len
//    not taken until handshake; next message then hashes correctly.
//  5 push 6 bytes into FIFO_DEPTH=4 while IDLE -> s_data_ready=0 after 4; len=6 then drains all.
//  6 rst_n low mid-STREAM (2 of 8 bytes sent) -> all outputs at reset values same cycle, FIFO
//    empty; afterwards len=2 msg 00 FF gives golden digest.

Source files
------------

// File: rtl/hash_msg_feeder.sv
// Front end for the byte-serial hash core: latches the message length, buffers bytes in a
// small FIFO, streams them to the core and holds the resulting digest on a valid/ready channel.
module hash_msg_feeder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_len_valid,
  input  logic [63:0] s_len,
  output logic        s_len_ready,
  input  logic        s_data_valid,
  input  logic [7:0]  s_data,
  output logic        s_data_ready,
  output logic        core_M_valid,
  output logic [7:0]  core_M,
  output logic [63:0] core_C_in,
  input  logic        core_hash_ready,
  input  logic [31:0] core_digest,
  output logic        digest_valid,
  output logic [31:0] digest,
  input  logic        digest_ready,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] len_reg, len_next;
  logic [63:0] remaining_reg, remaining_next;
  logic [31:0] digest_reg, digest_next;
  logic        digest_valid_reg, digest_valid_next;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          fifo_empty, fifo_full, push, pop;
  logic [7:0]    fifo_head;

  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == DEPTH_C);
  assign fifo_head    = fifo_mem[rd_ptr_reg];
  assign s_data_ready = !fifo_full;
  assign push         = s_data_valid && !fifo_full;

  assign core_C_in    = len_reg;
  assign digest       = digest_reg;
  assign digest_valid = digest_valid_reg;
  assign busy         = (state_reg != ST_IDLE);

  // Storage is not reset; the pointers alone define what the FIFO holds.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      len_reg          <= '0;
      remaining_reg    <= '0;
      digest_reg       <= '0;
      digest_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      len_reg          <= len_next;
      remaining_reg    <= remaining_next;
      digest_reg       <= digest_next;
      digest_valid_reg <= digest_valid_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    len_next          = len_reg;
    remaining_next    = remaining_reg;
    digest_next       = digest_reg;
    digest_valid_next = digest_valid_reg;
    s_len_ready       = 1'b0;
    core_M_valid      = 1'b0;
    core_M            = 8'h00;
    pop               = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        s_len_ready = 1'b1;
        if (s_len_valid) begin
          len_next       = s_len;
          remaining_next = s_len;
          state_next     = ST_START;
        end
      end

      // The core's init cycle needs exactly one valid beat; an empty message sends a dummy 00.
      ST_START: begin
        if (len_reg == '0) begin
          core_M_valid = 1'b1;
          state_next   = ST_WAIT;
        end else if (!fifo_empty) begin
          core_M_valid = 1'b1;
          core_M       = fifo_head;
          pop          = 1'b1;
          if (remaining_reg != '0) remaining_next = remaining_reg - 64'd1;
          state_next   = (remaining_reg > 64'd1) ? ST_STREAM : ST_WAIT;
        end
      end

      ST_STREAM: begin
        if (remaining_reg == '0) begin
          state_next = ST_WAIT;
        end else if (!fifo_empty) begin
          core_M_valid   = 1'b1;
          core_M         = fifo_head;
          pop            = 1'b1;
          remaining_next = remaining_reg - 64'd1;
          if (remaining_reg == 64'd1) state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (core_hash_ready) begin
          digest_next       = core_digest;
          digest_valid_next = 1'b1;
          state_next        = ST_DONE;
        end
      end

      ST_DONE: begin
        if (digest_ready) begin
          digest_valid_next = 1'b0;
          state_next        = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule
